dual_issue_hazard_ctrl: RTL and testbench

Hazard and issue controller for the dual-PE pipeline; it sequences the decode/execute boundary for PE1 and PE2. Each cycle it checks the decoded bundle against itself and against the execute stage. From that check it drives fetch/decode stalls and per-PE execute bubbles. When PE2 depends on PE1 within the same bundle, it splits the bundle over two cycles. It also keeps saturating performance counters for split and load-use stall events.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/dual_issue_hazard_ctrl_if.sv | 25 ++
 rtl/reg_match.sv | 14 +
 rtl/dual_issue_hazard_ctrl.sv | 77 +++++++
 tb/tb_dual_issue_hazard_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and helpers for the dual-issue hazard controller
package hazard_pkg;
    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 16;
    localparam int REG_ZERO   = 0;

    typedef enum logic {RUN, SPLIT} state_e;

    // Increments v unless it already holds the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v == max_v) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/dual_issue_hazard_ctrl_if.sv
// dual_issue_hazard_ctrl_if: decode/execute hazard inputs and stall/flush/counter outputs
//   slave  : the hazard controller (consumes indices/enables, drives stalls/flushes/counters)
//   master : the pipeline side (drives indices/enables, observes stalls/flushes/counters)
interface dual_issue_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] RS1_D1, RS2_D1, RD_D1, RS1_D2, RS2_D2, RD_D2, RD_E1, RD_E2;
    logic              RegWriteD1, RegWriteD2, RegWriteE1, RegWriteE2;
    logic              ResultSrcE1, ResultSrcE2, PCSrcE;
    logic              StallF, StallD, FlushD, FlushE1, FlushE2, SplitD;
    logic [CNT_W-1:0]  SplitCnt, LoadUseCnt;

    modport slave (
        input  RS1_D1, RS2_D1, RD_D1, RegWriteD1, RS1_D2, RS2_D2, RD_D2, RegWriteD2,
               RD_E1, RD_E2, RegWriteE1, RegWriteE2, ResultSrcE1, ResultSrcE2, PCSrcE,
        output StallF, StallD, FlushD, FlushE1, FlushE2, SplitD, SplitCnt, LoadUseCnt
    );

    modport master (
        output RS1_D1, RS2_D1, RD_D1, RegWriteD1, RS1_D2, RS2_D2, RD_D2, RegWriteD2,
               RD_E1, RD_E2, RegWriteE1, RegWriteE2, ResultSrcE1, ResultSrcE2, PCSrcE,
        input  StallF, StallD, FlushD, FlushE1, FlushE2, SplitD, SplitCnt, LoadUseCnt
    );
endinterface

// File: rtl/reg_match.sv
// reg_match: register-index comparator; m = en && a != x0 && a == b
//   a : destination index (x0 never matches), b : compared index, en : qualifier
module reg_match
    import hazard_pkg::*;
#(
    parameter int W = REG_AW_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         en,
    output logic         m
);
    assign m = en && (a != W'(REG_ZERO)) && (a == b);
endmodule

// File: rtl/dual_issue_hazard_ctrl.sv
// dual_issue_hazard_ctrl: decode/execute hazard and issue control for the dual-PE pipeline
//   clk : rising-edge clock, rst : asynchronous active-low reset
//   bus : slave side of dual_issue_hazard_ctrl_if (hazard inputs, stall/flush/counter outputs)
module dual_issue_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic                     clk,
    input logic                     rst,
    dual_issue_hazard_ctrl_if.slave bus
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  split_cnt_q, split_cnt_d, lu_cnt_q, lu_cnt_d;
    logic [REG_AW-1:0] src [4];
    logic [REG_AW-1:0] rde [2];
    logic [1:0]        lde;
    logic [7:0]        lu_m;
    logic [2:0]        dep_m;
    logic              run, dep, lu_x, split_ev, act;

    assign src[0] = bus.RS1_D1;
    assign src[1] = bus.RS2_D1;
    assign src[2] = bus.RS1_D2;
    assign src[3] = bus.RS2_D2;
    assign rde[0] = bus.RD_E1;
    assign rde[1] = bus.RD_E2;
    assign lde    = {bus.RegWriteE2 & bus.ResultSrcE2, bus.RegWriteE1 & bus.ResultSrcE1};

    // lu_m[4*k+j]: EX slot k is a load whose destination feeds decode source j
    for (genvar k = 0; k < 2; k++) begin : g_ex
        for (genvar j = 0; j < 4; j++) begin : g_src
            reg_match #(.W(REG_AW)) u_lu (.a(rde[k]), .b(src[j]), .en(lde[k]), .m(lu_m[4*k+j]));
        end
    end

    reg_match #(.W(REG_AW)) u_raw1 (.a(bus.RD_D1), .b(bus.RS1_D2), .en(bus.RegWriteD1), .m(dep_m[0]));
    reg_match #(.W(REG_AW)) u_raw2 (.a(bus.RD_D1), .b(bus.RS2_D2), .en(bus.RegWriteD1), .m(dep_m[1]));
    reg_match #(.W(REG_AW)) u_waw (.a(bus.RD_D1), .b(bus.RD_D2),
                                   .en(bus.RegWriteD1 & bus.RegWriteD2), .m(dep_m[2]));

    assign run = (state_q == RUN);
    assign dep = |dep_m;
    // In SPLIT only PE2 remains in decode, so only its sources can cause a load-use stall.
    assign lu_x     = !bus.PCSrcE && (run ? |lu_m : |{lu_m[7:6], lu_m[3:2]});
    assign split_ev = run && !bus.PCSrcE && !lu_x && dep;
    assign act      = rst;

    always_comb begin
        bus.StallF  = act && (lu_x || split_ev);
        bus.StallD  = act && (lu_x || split_ev);
        bus.FlushD  = act && bus.PCSrcE;
        // SPLIT always squashes PE1 since it already issued in the previous cycle.
        bus.FlushE1 = act && (bus.PCSrcE || lu_x || !run);
        bus.FlushE2 = act && (bus.PCSrcE || lu_x || split_ev);
        bus.SplitD  = act && !run;
        state_d     = bus.PCSrcE ? RUN : split_ev ? SPLIT : (!run && lu_x) ? SPLIT : RUN;
        split_cnt_d = split_ev ? CNT_W'(sat_inc(32'(split_cnt_q), CNT_W)) : split_cnt_q;
        lu_cnt_d    = lu_x ? CNT_W'(sat_inc(32'(lu_cnt_q), CNT_W)) : lu_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            split_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            split_cnt_q <= split_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign bus.SplitCnt   = split_cnt_q;
    assign bus.LoadUseCnt = lu_cnt_q;
endmodule

// File: tb/tb_dual_issue_hazard_ctrl.sv
// tb_dual_issue_hazard_ctrl: directed checks of the dual-issue hazard controller
module tb_dual_issue_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    dual_issue_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) a ();
    dual_issue_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  b ();

    dual_issue_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(a.slave));
    dual_issue_hazard_ctrl #(.REG_AW(5), .CNT_W(4))  dut_sat (.clk(clk), .rst(rst), .bus(b.slave));

    assign b.RS1_D1      = a.RS1_D1;
    assign b.RS2_D1      = a.RS2_D1;
    assign b.RD_D1       = a.RD_D1;
    assign b.RegWriteD1  = a.RegWriteD1;
    assign b.RS1_D2      = a.RS1_D2;
    assign b.RS2_D2      = a.RS2_D2;
    assign b.RD_D2       = a.RD_D2;
    assign b.RegWriteD2  = a.RegWriteD2;
    assign b.RD_E1       = a.RD_E1;
    assign b.RD_E2       = a.RD_E2;
    assign b.RegWriteE1  = a.RegWriteE1;
    assign b.RegWriteE2  = a.RegWriteE2;
    assign b.ResultSrcE1 = a.ResultSrcE1;
    assign b.ResultSrcE2 = a.ResultSrcE2;
    assign b.PCSrcE      = a.PCSrcE;

    // {StallF, StallD, FlushD, FlushE1, FlushE2, SplitD}
    function automatic int outs();
        return int'({a.StallF, a.StallD, a.FlushD, a.FlushE1, a.FlushE2, a.SplitD});
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        a.RS1_D1 = 0; a.RS2_D1 = 0; a.RD_D1 = 0; a.RegWriteD1 = 0;
        a.RS1_D2 = 0; a.RS2_D2 = 0; a.RD_D2 = 0; a.RegWriteD2 = 0;
        a.RD_E1 = 0; a.RD_E2 = 0; a.RegWriteE1 = 0; a.RegWriteE2 = 0;
        a.ResultSrcE1 = 0; a.ResultSrcE2 = 0; a.PCSrcE = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic raw_bundle();
        clear();
        a.RD_D1 = 3; a.RegWriteD1 = 1; a.RS1_D2 = 3;
    endtask

    initial begin
        rst = 1'b0;
        clear();
        a.RD_D1 = 9; a.RegWriteD1 = 1; a.RS1_D2 = 9;
        #1;
        chk("reset_outs", outs(), 6'b000000);
        chk("reset_split_cnt", int'(a.SplitCnt), 0);
        chk("reset_lu_cnt", int'(a.LoadUseCnt), 0);
        step();
        rst = 1'b1;
        // independent bundle
        clear();
        a.RD_D1 = 5; a.RegWriteD1 = 1; a.RS1_D2 = 6; a.RS2_D2 = 7;
        #1 chk("indep_c0", outs(), 6'b000000);
        step();
        #1 chk("indep_c1", outs(), 6'b000000);
        chk("indep_cnt", int'(a.SplitCnt) + int'(a.LoadUseCnt), 0);
        step();
        // RAW inside bundle -> split
        raw_bundle();
        #1 chk("raw_c0", outs(), 6'b110010);
        step();
        #1 chk("raw_c1", outs(), 6'b000101);
        step();
        clear();
        #1 chk("raw_c2", outs(), 6'b000000);
        chk("raw_split_cnt", int'(a.SplitCnt), 1);
        // WAW inside bundle also splits
        clear();
        a.RD_D1 = 12; a.RegWriteD1 = 1; a.RD_D2 = 12; a.RegWriteD2 = 1;
        #1 chk("waw_c0", outs(), 6'b110010);
        step();
        #1 chk("waw_c1", outs(), 6'b000101);
        step();
        clear();
        #1 chk("waw_cnt", int'(a.SplitCnt), 2);
        // load-use against PE1 source
        a.RegWriteE1 = 1; a.ResultSrcE1 = 1; a.RD_E1 = 4; a.RS2_D1 = 4;
        #1 chk("lu_c0", outs(), 6'b110110);
        step();
        clear();
        #1 chk("lu_c1", outs(), 6'b000000);
        chk("lu_cnt", int'(a.LoadUseCnt), 1);
        // load into x0 never stalls
        a.RegWriteE1 = 1; a.ResultSrcE1 = 1; a.RD_E1 = 0; a.RS2_D1 = 0;
        #1 chk("lu_x0", outs(), 6'b000000);
        step();
        // load in EX slot 2 against PE2 source
        clear();
        a.RegWriteE2 = 1; a.ResultSrcE2 = 1; a.RD_E2 = 17; a.RS1_D2 = 17;
        #1 chk("lu_e2", outs(), 6'b110110);
        step();
        clear();
        #1 chk("lu_e2_cnt", int'(a.LoadUseCnt), 2);
        // split followed by load-use in SPLIT
        a.RD_D1 = 8; a.RegWriteD1 = 1; a.RS1_D2 = 8;
        #1 chk("sl_c0", outs(), 6'b110010);
        step();
        a.RD_E1 = 8; a.RegWriteE1 = 1; a.ResultSrcE1 = 1;
        #1 chk("sl_c1", outs(), 6'b110111);
        step();
        a.RD_E1 = 0; a.RegWriteE1 = 0; a.ResultSrcE1 = 0;
        #1 chk("sl_c2", outs(), 6'b000101);
        step();
        clear();
        #1 chk("sl_c3", outs(), 6'b000000);
        chk("sl_split_cnt", int'(a.SplitCnt), 3);
        chk("sl_lu_cnt", int'(a.LoadUseCnt), 3);
        // taken branch while in SPLIT
        raw_bundle();
        step();
        a.PCSrcE = 1;
        #1 chk("br_split", outs(), 6'b001111);
        step();
        clear();
        #1 chk("br_after", outs(), 6'b000000);
        chk("br_split_cnt", int'(a.SplitCnt), 4);
        chk("br_lu_cnt", int'(a.LoadUseCnt), 3);
        // branch together with load-use and dep in RUN: flush only, no counting
        raw_bundle();
        a.RegWriteE1 = 1; a.ResultSrcE1 = 1; a.RD_E1 = 6; a.RS1_D1 = 6; a.PCSrcE = 1;
        #1 chk("br_lu_run", outs(), 6'b001110);
        step();
        clear();
        #1 chk("br_lu_split_cnt", int'(a.SplitCnt), 4);
        chk("br_lu_lu_cnt", int'(a.LoadUseCnt), 3);
        // asynchronous reset in the middle of SPLIT
        raw_bundle();
        step();
        #1 chk("rst_pre", outs(), 6'b000101);
        rst = 1'b0;
        #1 chk("rst_mid_outs", outs(), 6'b000000);
        chk("rst_mid_cnt", int'(a.SplitCnt), 0);
        step();
        rst = 1'b1;
        #1 chk("rst_release", outs(), 6'b110010);
        // 20 back-to-back splits: 4-bit counter saturates, 16-bit one does not
        for (int i = 0; i < 20; i++) begin
            step();
            step();
        end
        clear();
        #1 chk("sat_cnt4", int'(b.SplitCnt), 15);
        chk("sat_cnt16", int'(a.SplitCnt), 20);
        chk("sat_lu_cnt4", int'(b.LoadUseCnt), 0);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
